// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Loads a host program into the RISC-V core's instruction memory (32-bit
//   words) or data memory (64-bit words, assembled from two 32-bit beats)
//   through a valid/ready stream. After loading, it drives the core enable
//   on run_req and drops it on halt.
//   Optional feature macro: LOADER_CHECKSUM_EN -- when defined, every load
//   ends with one extra beat carrying the mod-2^32 sum of the payload beats.
module cpu_program_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             target,
  input  logic [LEN_W-1:0] num_words,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic             run_req,
  input  logic             halt,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_I    = 3'd1,
    S_LOAD_D_LO = 3'd2,
    S_LOAD_D_HI = 3'd3,
    S_FINISH    = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  // Capacities widened by one bit so a count equal to 2^LEN_W-1 still
  // compares correctly against the depth.
  localparam logic [LEN_W:0] IMEM_CAP = (LEN_W+1)'(IMEM_DEPTH);
  localparam logic [LEN_W:0] DMEM_CAP = (LEN_W+1)'(DMEM_DEPTH);

  state_t           r_state;
  state_t           w_next_state;

  logic [LEN_W-1:0] r_index;      // current memory word index
  logic [LEN_W-1:0] r_last;       // index of the final word of this load
  logic [31:0]      r_lo;         // low half of the data word being built
  logic             r_error;

  logic [63:0]      r_addr_i;
  logic             r_wen_i;
  logic [31:0]      r_wdata_i;
  logic [63:0]      r_addr_d;
  logic             r_wen_d;
  logic [63:0]      r_wdata_d;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;        // running sum of payload beats
`endif

  logic [LEN_W:0]   w_cap;
  logic             w_oversize;
  logic             w_start_ok;
  logic             w_start_oversize;
  logic             w_beat;
  logic             w_last;

  assign w_cap            = target ? DMEM_CAP : IMEM_CAP;
  assign w_oversize       = {1'b0, num_words} > w_cap;
  assign w_start_ok       = (r_state == S_IDLE) && start && !w_oversize;
  assign w_start_oversize = (r_state == S_IDLE) && start && w_oversize;
  assign w_beat           = s_valid && s_ready;
  assign w_last           = (r_index == r_last);

  assign addr_ext    = r_addr_i;
  assign wen_ext     = r_wen_i;
  assign wdata_ext   = r_wdata_i;
  assign addr_ext_2  = r_addr_d;
  assign wen_ext_2   = r_wen_d;
  assign wdata_ext_2 = r_wdata_d;
  assign error       = r_error;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_next_state = r_state;
    s_ready      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    cpu_enable   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // start takes priority over run_req; an oversize start stays here.
        if (start) begin
          if (!w_oversize) begin
            if (num_words == '0) begin
              w_next_state = S_FINISH;
            end else if (target) begin
              w_next_state = S_LOAD_D_LO;
            end else begin
              w_next_state = S_LOAD_I;
            end
          end
        end else if (run_req && !r_error) begin
          w_next_state = S_RUN;
        end
      end

      S_LOAD_I: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && w_last) begin
          w_next_state = S_FINISH;
        end
      end

      S_LOAD_D_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          w_next_state = S_LOAD_D_HI;
        end
      end

      S_LOAD_D_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          w_next_state = w_last ? S_FINISH : S_LOAD_D_LO;
        end
      end

      S_FINISH: begin
`ifdef LOADER_CHECKSUM_EN
        // Hold here until the checksum beat arrives; done marks its acceptance.
        s_ready = 1'b1;
        if (s_valid) begin
          done         = 1'b1;
          w_next_state = S_IDLE;
        end
`else
        done         = 1'b1;
        w_next_state = S_IDLE;
`endif
      end

      S_RUN: begin
        cpu_enable = 1'b1;
        if (halt) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Load datapath: word index, error flag, low-half latch and write ports.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_index   <= '0;
      r_last    <= '0;
      r_lo      <= '0;
      r_error   <= 1'b0;
      r_addr_i  <= '0;
      r_wen_i   <= 1'b0;
      r_wdata_i <= '0;
      r_addr_d  <= '0;
      r_wen_d   <= 1'b0;
      r_wdata_d <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      // Write enables are single-cycle strobes; address and data hold.
      r_wen_i <= 1'b0;
      r_wen_d <= 1'b0;

      if (w_start_ok) begin
        r_index <= '0;
        r_last  <= num_words - LEN_W'(1);
        r_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= '0;
`endif
      end else if (w_start_oversize) begin
        r_error <= 1'b1;
      end

      if (w_beat) begin
        unique case (r_state)
          S_LOAD_I: begin
            r_wen_i   <= 1'b1;
            r_addr_i  <= 64'({r_index, 2'b00});
            r_wdata_i <= s_data;
            r_index   <= r_index + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= r_sum + s_data;
`endif
          end
          S_LOAD_D_LO: begin
            r_lo <= s_data;
`ifdef LOADER_CHECKSUM_EN
            r_sum <= r_sum + s_data;
`endif
          end
          S_LOAD_D_HI: begin
            r_wen_d   <= 1'b1;
            r_addr_d  <= 64'({r_index, 3'b000});
            r_wdata_d <= {s_data, r_lo};
            r_index   <= r_index + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= r_sum + s_data;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_FINISH: begin
            // A bad checksum blocks run_req until the next clean load.
            if (s_data != r_sum) begin
              r_error <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader
//   Directed bench for cpu_program_loader. Write strobes are logged into
//   queues on the falling edge and compared against hand-computed values.
//   Define LOADER_CHECKSUM_EN for the bench and RTL together to exercise the
//   trailing checksum beat.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        target;
  logic [15:0] num_words;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        run_req;
  logic        halt;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_sum;

  logic [63:0] iq_a[$];
  logic [63:0] iq_d[$];
  logic [63:0] dq_a[$];
  logic [63:0] dq_d[$];

  cpu_program_loader dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .target      (target),
    .num_words   (num_words),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .run_req     (run_req),
    .halt        (halt),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Write logger, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (wen_ext) begin
      iq_a.push_back(addr_ext);
      iq_d.push_back({32'h0, wdata_ext});
    end
    if (wen_ext_2) begin
      dq_a.push_back(addr_ext_2);
      dq_d.push_back(wdata_ext_2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iq_a.delete();
    iq_d.delete();
    dq_a.delete();
    dq_d.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},     s_ready,     0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_done"},        done,        0);
    check({tag, "_error"},       error,       0);
    check({tag, "_cpu_enable"},  cpu_enable,  0);
    check({tag, "_wen_ext"},     wen_ext,     0);
    check({tag, "_addr_ext"},    addr_ext,    0);
    check({tag, "_wdata_ext"},   wdata_ext,   0);
    check({tag, "_wen_ext_2"},   wen_ext_2,   0);
    check({tag, "_addr_ext_2"},  addr_ext_2,  0);
    check({tag, "_wdata_ext_2"}, wdata_ext_2, 0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
  endtask

  task automatic start_load(input logic tgt, input logic [15:0] n);
    start     = 1'b1;
    target    = tgt;
    num_words = n;
    tb_sum    = '0;
    step();
    start     = 1'b0;
  endtask

  // Offer one beat, wait (bounded) for s_ready, and let one edge accept it.
  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    check("beat_ready", s_ready, 1);
    step();
    s_valid = 1'b0;
    tb_sum  = tb_sum + d;
  endtask

  // Complete the load: checksum beat when enabled, then done and idle.
  task automatic finish_load(input logic [31:0] csum, input logic exp_wen);
    s_data = csum;
`ifdef LOADER_CHECKSUM_EN
    s_valid = 1'b1;
    #1;
    check("csum_ready", s_ready, 1);
    check("done_pulse", done, 1);
    step();
    s_valid = 1'b0;
`else
    check("done_pulse", done, 1);
    check("done_with_write", wen_ext | wen_ext_2, exp_wen);
    step();
`endif
    check("done_cleared", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    arst_n    = 1'b0;
    start     = 1'b0;
    target    = 1'b0;
    num_words = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    run_req   = 1'b0;
    halt      = 1'b0;
    tb_sum    = '0;

    // Reset state.
    step();
    step();
    check_all_zero("reset");
    arst_n = 1'b1;
    step();

    // Instruction load, three beats, valid held high.
    clear_logs();
    start_load(1'b0, 16'd3);
    check("iload_busy", busy, 1);
    check("iload_ready", s_ready, 1);
    send_beat(32'h00500093);
    send_beat(32'h00100113);
    send_beat(32'h002081B3);
    finish_load(tb_sum, 1'b1);
    check("iload_count", iq_a.size(), 3);
    check("iload_a0", iq_a[0], 64'd0);
    check("iload_d0", iq_d[0], 64'h00500093);
    check("iload_a1", iq_a[1], 64'd4);
    check("iload_d1", iq_d[1], 64'h00100113);
    check("iload_a2", iq_a[2], 64'd8);
    check("iload_d2", iq_d[2], 64'h002081B3);
    check("iload_no_dwrite", dq_a.size(), 0);

    // Data load, two words, valid toggling with a stall after each beat.
    clear_logs();
    start_load(1'b1, 16'd2);
    check("dload_busy", busy, 1);
    send_beat(32'h1);
    step();
    check("dload_stall0", wen_ext_2, 0);
    send_beat(32'h2);
    step();
    check("dload_stall1", wen_ext_2, 0);
    send_beat(32'h3);
    step();
    check("dload_stall2", wen_ext_2, 0);
    send_beat(32'h4);
    finish_load(tb_sum, 1'b1);
    check("dload_count", dq_a.size(), 2);
    check("dload_a0", dq_a[0], 64'd0);
    check("dload_d0", dq_d[0], 64'h0000000200000001);
    check("dload_a1", dq_a[1], 64'd8);
    check("dload_d1", dq_d[1], 64'h0000000400000003);
    check("dload_no_iwrite", iq_a.size(), 0);
    check("dload_addr_hold", addr_ext_2, 64'd8);
    check("dload_data_hold", wdata_ext_2, 64'h0000000400000003);

    // Oversize instruction load, then run_req must be ignored.
    clear_logs();
    start_load(1'b0, 16'd513);
    check("over_error", error, 1);
    check("over_ready", s_ready, 0);
    check("over_busy", busy, 0);
    step();
    check("over_ready_later", s_ready, 0);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    check("over_run_ignored", cpu_enable, 0);
    step();
    check("over_run_ignored2", cpu_enable, 0);
    check("over_no_write", iq_a.size() + dq_a.size(), 0);

    // Capacity boundaries: exactly full loads are accepted.
    start_load(1'b0, 16'd512);
    check("imem_full_busy", busy, 1);
    check("imem_full_err_clr", error, 0);
    do_reset();
    start_load(1'b1, 16'd1025);
    check("dmem_over_error", error, 1);
    check("dmem_over_busy", busy, 0);
    start_load(1'b1, 16'd1024);
    check("dmem_full_busy", busy, 1);
    check("dmem_full_err_clr", error, 0);
    do_reset();

    // Zero-length load: straight to FINISH, no writes.
    clear_logs();
    start_load(1'b0, 16'd0);
    check("zero_busy", busy, 0);
    finish_load(tb_sum, 1'b0);
    step();
    check("zero_no_write", iq_a.size() + dq_a.size(), 0);

    // Clean load, run, start ignored while running, halt.
    clear_logs();
    start_load(1'b0, 16'd1);
    send_beat(32'hDEADBEEF);
    finish_load(tb_sum, 1'b1);
    check("clean_error", error, 0);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    check("run_enable", cpu_enable, 1);
    check("run_ready", s_ready, 0);
    start     = 1'b1;
    target    = 1'b0;
    num_words = 16'd1;
    step();
    start = 1'b0;
    check("run_start_ignored_en", cpu_enable, 1);
    check("run_start_ignored_busy", busy, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_disable", cpu_enable, 0);

    // start and run_req together: start wins.
    start     = 1'b1;
    run_req   = 1'b1;
    target    = 1'b0;
    num_words = 16'd1;
    tb_sum    = '0;
    step();
    start   = 1'b0;
    run_req = 1'b0;
    check("prio_busy", busy, 1);
    check("prio_enable", cpu_enable, 0);
    send_beat(32'h12345678);
    finish_load(tb_sum, 1'b1);
    check("prio_count", iq_a.size(), 2);
    check("prio_d0", iq_d[0], 64'hDEADBEEF);
    check("prio_a1", iq_a[1], 64'd0);
    check("prio_d1", iq_d[1], 64'h12345678);

    // Reset after two of four beats abandons the load.
    clear_logs();
    start_load(1'b0, 16'd4);
    send_beat(32'h11);
    send_beat(32'h22);
    arst_n  = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h33;
    step();
    check_all_zero("midreset");
    arst_n = 1'b1;
    step();
    step();
    s_valid = 1'b0;
    check("midreset_count", iq_a.size(), 2);
    check("midreset_a1", iq_a[1], 64'd4);
    check("midreset_d1", iq_d[1], 64'h22);
    start_load(1'b0, 16'd1);
    send_beat(32'h55);
    finish_load(tb_sum, 1'b1);
    check("reload_count", iq_a.size(), 3);
    check("reload_a", iq_a[2], 64'd0);
    check("reload_d", iq_d[2], 64'h55);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: error set, done still pulses, run_req ignored.
    start_load(1'b0, 16'd2);
    send_beat(32'd5);
    send_beat(32'd7);
    finish_load(32'd13, 1'b1);
    check("csum_bad_error", error, 1);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    check("csum_bad_no_run", cpu_enable, 0);

    // Good checksum: error clear, core runs.
    start_load(1'b0, 16'd2);
    send_beat(32'd5);
    send_beat(32'd7);
    finish_load(32'd12, 1'b1);
    check("csum_good_error", error, 0);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    check("csum_good_run", cpu_enable, 1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("csum_good_halt", cpu_enable, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
